move_sequencer: RTL and testbench
=================================

Name: move_sequencer

Overview:
- Turn controller and board owner for the 3x3 game.
- Sequences player and computer moves into a single board register and validates each move.
- After each write it evaluates win/draw and produces the wrong_move, filled and win status consumed by the top-level gameplay FSM.
- Hands the turn to the computer move engine through a req/valid handshake, with a timeout.

Parameters:
- TIMEOUT, 255, max clock cycles comp_req may stay high without an accepted computer move before the computer forfeits
- TW, 8, width of the timeout counter; must satisfy TIMEOUT < 2^TW

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  synchronous new-game strobe: clears board, returns to IDLE
- play  in  1  player move valid, single-cycle pulse
- player_pos  in  4  player cell index 0..8, row-major
- comp_req  out  1  request to computer engine for a move
- comp_valid  in  1  computer move valid; sampled only while comp_req=1
- comp_pos  in  4  computer cell index 0..8
- board  out  18  cell i at bits [2i+1:2i]; 00 empty, 01 player, 10 computer
- wrong_move  out  1  one-cycle pulse: rejected player move
- comp_err  out  1  one-cycle pulse: rejected computer move
- filled  out  1  all 9 cells non-empty
- win  out  1  game won (level, held in OVER)
- winner  out  2  01 player, 10 computer, 00 none/draw
- timeout  out  1  computer forfeited (level, held in OVER)
- busy  out  1  high in every state except IDLE and OVER

Behaviour:
- Reset (asynchronous, reset=0) clears everything: board=0, state=IDLE, timeout counter=0, and all outputs 0.
- States: IDLE, P_CHECK, EVAL, C_REQ, OVER.
- start=1 has priority over every other input in any state. Next cycle: board=0, win/winner/timeout cleared, state=IDLE.
- IDLE:
  - play=1 latches player_pos and moves to P_CHECK.
  - play is ignored in every other state.
- P_CHECK:
  - If pos>8 or the cell is non-empty: wrong_move=1 for this cycle, board unchanged, next state IDLE.
  - Otherwise write 01 to the cell, set mover=player, next state EVAL.
- EVAL (one cycle after the write; evaluates the updated board for the mover's mark):
  - Win on any of the 8 lines: win=1, winner=mover, next state OVER.
  - Else if filled: next state OVER with winner=00 (draw).
  - Else if mover=player: next state C_REQ, timeout counter cleared.
  - Else: next state IDLE.
- C_REQ:
  - comp_req=1 while in this state; the counter increments every cycle.
  - comp_valid=1 with comp_pos<=8 and the cell empty: write 10, mover=computer, comp_req drops the next cycle, next state EVAL.
  - comp_valid=1 with an invalid or occupied cell: comp_err=1 for one cycle, stay in C_REQ, counter keeps running.
  - Counter reaches TIMEOUT with no accepted move: timeout=1, win=1, winner=01, next state OVER.
  - comp_valid on the same cycle the counter hits TIMEOUT: the move wins and is accepted.
- OVER:
  - board, win, winner, timeout hold; all moves are ignored.
  - Exit only via start or reset.
- Status outputs:
  - filled is combinational from board (every 2-bit field non-zero).
  - win, winner and timeout are registered.
- Latency:
  - Player move to player's board write: 1 cycle after the play pulse.
  - Player's board write to comp_req rising: 1 cycle (via EVAL).
  - Accepted comp_valid to board write: same edge.
- Pulses and states:
  - wrong_move and comp_err never assert together.
  - Encoding 11 is never written to any cell.
  - Illegal state encodings recover to IDLE.
- Reset mid-operation aborts immediately; comp_req falls asynchronously.

Decomposition:
- Shared package holds:
  - cell codes EMPTY/PLAYER/COMP
  - state encoding
  - the 8 win-line index triples {0,1,2}{3,4,5}{6,7,8}{0,3,6}{1,4,7}{2,5,8}{0,4,8}{2,4,6}
- One combinational sub-module, line_checker:
  - inputs: 18-bit board and a 2-bit mark
  - outputs: line_hit and the line index for debug
- line_checker is instantiated once in EVAL, with the mark selected by mover.

Test Plan:
- Basic handoff: reset low then high, play pos=4 → board[9:8]=01 one cycle later; comp_req=1 two cycles after play. Drive comp_valid pos=0 → board[1:0]=10, comp_req=0, back in IDLE.
- Illegal player move: play pos=4 when cell 4 is occupied, then play pos=9 → wrong_move pulses once for each, board unchanged, state IDLE both times.
- Player win and hold: player moves 0,1,2 with computer moves 3,4 → win=1, winner=01, busy=0. A further play is ignored; start clears board to 0 and state returns to IDLE.
- Computer timeout: TIMEOUT=4, never assert comp_valid → timeout=1, winner=01 after 4 cycles of comp_req. Separately, comp_valid on the 4th cycle with a legal pos → move accepted, timeout=0.
- Illegal computer move and draw: comp_valid with an occupied pos → comp_err pulse, comp_req stays 1. A full draw sequence ending with filled=1 → OVER, win=0, winner=00.
- Mid-game reset: reset=0 asserted while in C_REQ → comp_req=0 and board=0 within the same cycle; normal play resumes after release.

Source files
------------

// File: rtl/move_sequencer_pkg.sv
// ============================================================================
//  move_sequencer_pkg
//  Cell codes, FSM state encoding, win-line table and board helpers.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package move_sequencer_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY  = 2'b00,
    CELL_PLAYER = 2'b01,
    CELL_COMP   = 2'b10
  } cell_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_P_CHECK = 3'd1,
    ST_EVAL    = 3'd2,
    ST_C_REQ   = 3'd3,
    ST_OVER    = 3'd4
  } state_e;

  localparam int c_num_cells = 9;
  localparam int c_num_lines = 8;

  localparam int c_win_lines [c_num_lines][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  // Out-of-range indices read as 11 so they never look empty.
  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
    logic [1:0] r;
    r = 2'b11;
    for (int i = 0; i < c_num_cells; i++) begin
      if (idx == 4'(i)) r = b[2*i +: 2];
    end
    return r;
  endfunction

  function automatic logic [17:0] set_cell(input logic [17:0] b, input logic [3:0] idx,
                                           input logic [1:0] code);
    logic [17:0] r;
    r = b;
    for (int i = 0; i < c_num_cells; i++) begin
      if (idx == 4'(i)) r[2*i +: 2] = code;
    end
    return r;
  endfunction

  function automatic logic board_full(input logic [17:0] b);
    logic r;
    r = 1'b1;
    for (int i = 0; i < c_num_cells; i++) begin
      if (b[2*i +: 2] == CELL_EMPTY) r = 1'b0;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/move_sequencer_if.sv
// ============================================================================
//  move_sequencer_if
//  Request/valid handshake between the sequencer and the computer move engine.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface move_sequencer_if;
  logic       comp_req;
  logic       comp_valid;
  logic [3:0] comp_pos;

  modport master (output comp_req, input comp_valid, input comp_pos);
  modport slave  (input comp_req, output comp_valid, output comp_pos);
endinterface

`default_nettype wire

// File: rtl/move_sequencer_line_checker.sv
// ============================================================================
//  line_checker
//  Flags any of the 8 win lines fully owned by i_mark; lowest line index wins.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module line_checker
  import move_sequencer_pkg::*;
(
  input  wire logic [17:0] i_board,
  input  wire logic [1:0]  i_mark,
  output logic             o_line_hit,
  output logic [2:0]       o_line_idx
);

  always_comb begin
    o_line_hit = 1'b0;
    o_line_idx = 3'd0;
    for (int l = c_num_lines - 1; l >= 0; l--) begin
      if (i_board[2*c_win_lines[l][0] +: 2] == i_mark &&
          i_board[2*c_win_lines[l][1] +: 2] == i_mark &&
          i_board[2*c_win_lines[l][2] +: 2] == i_mark) begin
        o_line_hit = 1'b1;
        o_line_idx = l[2:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/move_sequencer.sv
// ============================================================================
//  move_sequencer
//  Turn controller and board owner for the 3x3 game: validates moves, judges
//  win/draw and hands the turn to the computer engine with a timeout.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  wire logic         clock,
  input  wire logic         reset,
  input  wire logic         start,
  input  wire logic         play,
  input  wire logic [3:0]   player_pos,
  move_sequencer_if.master  comp,
  output logic [17:0]       board,
  output logic              wrong_move,
  output logic              comp_err,
  output logic              filled,
  output logic              win,
  output logic [1:0]        winner,
  output logic              timeout,
  output logic              busy
);

  state_e        r_state;
  cell_e         r_mover;
  logic [17:0]   r_board;
  logic [3:0]    r_pos;
  logic [TW-1:0] r_cnt;
  logic          r_comp_req;
  logic          r_wrong_move;
  logic          r_comp_err;
  logic          r_win;
  logic [1:0]    r_winner;
  logic          r_timeout;

  logic          w_line_hit;
  logic [2:0]    w_line_idx_unused;
  logic          w_filled;
  logic [TW-1:0] w_cnt_next;
  logic          w_comp_ok;

  line_checker u_line_checker (
    .i_board    (r_board),
    .i_mark     (r_mover),
    .o_line_hit (w_line_hit),
    .o_line_idx (w_line_idx_unused)
  );

  assign w_filled   = board_full(r_board);
  assign w_cnt_next = r_cnt + 1'b1;
  assign w_comp_ok  = comp.comp_valid && (cell_at(r_board, comp.comp_pos) == CELL_EMPTY);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_mover      <= CELL_EMPTY;
      r_board      <= '0;
      r_pos        <= '0;
      r_cnt        <= '0;
      r_comp_req   <= 1'b0;
      r_wrong_move <= 1'b0;
      r_comp_err   <= 1'b0;
      r_win        <= 1'b0;
      r_winner     <= 2'b00;
      r_timeout    <= 1'b0;
    end else begin
      r_wrong_move <= 1'b0;
      r_comp_err   <= 1'b0;
      if (start) begin
        r_state    <= ST_IDLE;
        r_mover    <= CELL_EMPTY;
        r_board    <= '0;
        r_cnt      <= '0;
        r_comp_req <= 1'b0;
        r_win      <= 1'b0;
        r_winner   <= 2'b00;
        r_timeout  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (play) begin
              r_pos   <= player_pos;
              r_state <= ST_P_CHECK;
            end
          end
          ST_P_CHECK: begin
            if (cell_at(r_board, r_pos) != CELL_EMPTY) begin
              r_wrong_move <= 1'b1;
              r_state      <= ST_IDLE;
            end else begin
              r_board <= set_cell(r_board, r_pos, CELL_PLAYER);
              r_mover <= CELL_PLAYER;
              r_state <= ST_EVAL;
            end
          end
          ST_EVAL: begin
            if (w_line_hit) begin
              r_win    <= 1'b1;
              r_winner <= r_mover;
              r_state  <= ST_OVER;
            end else if (w_filled) begin
              r_winner <= 2'b00;
              r_state  <= ST_OVER;
            end else if (r_mover == CELL_PLAYER) begin
              r_cnt      <= '0;
              r_comp_req <= 1'b1;
              r_state    <= ST_C_REQ;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_C_REQ: begin
            r_cnt <= w_cnt_next;
            // A legal move on the deadline cycle beats the forfeit.
            if (w_comp_ok) begin
              r_board    <= set_cell(r_board, comp.comp_pos, CELL_COMP);
              r_mover    <= CELL_COMP;
              r_comp_req <= 1'b0;
              r_state    <= ST_EVAL;
            end else begin
              r_comp_err <= comp.comp_valid;
              if (w_cnt_next == TW'(TIMEOUT)) begin
                r_timeout  <= 1'b1;
                r_win      <= 1'b1;
                r_winner   <= CELL_PLAYER;
                r_comp_req <= 1'b0;
                r_state    <= ST_OVER;
              end
            end
          end
          ST_OVER: begin
            r_state <= ST_OVER;
          end
          default: begin
            r_comp_req <= 1'b0;
            r_state    <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign comp.comp_req = r_comp_req;
  assign board         = r_board;
  assign wrong_move    = r_wrong_move;
  assign comp_err      = r_comp_err;
  assign filled        = w_filled;
  assign win           = r_win;
  assign winner        = r_winner;
  assign timeout       = r_timeout;
  assign busy          = (r_state != ST_IDLE) && (r_state != ST_OVER);

endmodule

`default_nettype wire

// File: tb/tb_move_sequencer.sv
// ============================================================================
//  tb_move_sequencer
//  Scenario tasks plus randomized games checked against a board-level model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_move_sequencer;

  localparam int TIMEOUT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        play;
  logic [3:0]  player_pos;
  logic [17:0] board;
  logic        wrong_move;
  logic        comp_err;
  logic        filled;
  logic        win;
  logic [1:0]  winner;
  logic        timeout;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  move_sequencer_if cif ();

  move_sequencer #(.TIMEOUT(TIMEOUT), .TW(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .play       (play),
    .player_pos (player_pos),
    .comp       (cif),
    .board      (board),
    .wrong_move (wrong_move),
    .comp_err   (comp_err),
    .filled     (filled),
    .win        (win),
    .winner     (winner),
    .timeout    (timeout),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Reference model: one int per cell, 0 empty, 1 player, 2 computer.
  int m_board [9];
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic void m_clear();
    for (int i = 0; i < 9; i++) m_board[i] = 0;
  endfunction

  function automatic logic [17:0] m_bits();
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_board[i]);
    return b;
  endfunction

  function automatic bit m_wins(int mark);
    for (int l = 0; l < 8; l++)
      if (m_board[lines[l][0]] == mark && m_board[lines[l][1]] == mark &&
          m_board[lines[l][2]] == mark) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < 9; i++) if (m_board[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_legal(int p);
    return (p <= 8) && (m_board[p] == 0);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_play(input int p);
    play = 1'b1;
    player_pos = 4'(p);
    tick();
    play = 1'b0;
    tick();
  endtask

  task automatic comp_move(input int p);
    cif.comp_valid = 1'b1;
    cif.comp_pos = 4'(p);
    tick();
    cif.comp_valid = 1'b0;
  endtask

  task automatic new_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_clear();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    play = 1'b0;
    player_pos = 4'd0;
    cif.comp_valid = 1'b0;
    cif.comp_pos = 4'd0;
    m_clear();
    tick();
    tick();
    n_checks++;
    if ({board, cif.comp_req, wrong_move, comp_err, filled, win, winner, timeout, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got board=%h req=%b wm=%b ce=%b f=%b w=%b wn=%b to=%b busy=%b, need all 0",
               board, cif.comp_req, wrong_move, comp_err, filled, win, winner, timeout, busy);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || board !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%b board=%h, need 0/0", busy, board);
    end
  endtask

  task automatic test_basic_handoff();
    play = 1'b1;
    player_pos = 4'd4;
    tick();
    play = 1'b0;
    n_checks++;
    if (board !== 18'h0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL handoff_pcheck: got board=%h busy=%b, need 0/1", board, busy);
    end
    tick();
    m_board[4] = 1;
    n_checks++;
    if (board !== m_bits() || wrong_move !== 1'b0) begin
      n_fail++;
      $display("FAIL handoff_pwrite: got board=%h wm=%b, need %h/0", board, wrong_move, m_bits());
    end
    tick();
    n_checks++;
    if (cif.comp_req !== 1'b1) begin
      n_fail++;
      $display("FAIL handoff_req: got comp_req=%b, need 1", cif.comp_req);
    end
    comp_move(0);
    m_board[0] = 2;
    n_checks++;
    if (board !== m_bits() || cif.comp_req !== 1'b0 || comp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL handoff_cwrite: got board=%h req=%b ce=%b, need %h/0/0",
               board, cif.comp_req, comp_err, m_bits());
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || win !== 1'b0 || cif.comp_req !== 1'b0) begin
      n_fail++;
      $display("FAIL handoff_idle: got busy=%b win=%b req=%b, need 0/0/0", busy, win, cif.comp_req);
    end
  endtask

  task automatic test_illegal_player();
    int bad [2] = '{4, 9};
    for (int k = 0; k < 2; k++) begin
      do_play(bad[k]);
      n_checks++;
      if (wrong_move !== 1'b1 || board !== m_bits() || busy !== 1'b0 || comp_err !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_player_%0d: got wm=%b board=%h busy=%b ce=%b, need 1/%h/0/0",
                 bad[k], wrong_move, board, busy, comp_err, m_bits());
      end
      tick();
      n_checks++;
      if (wrong_move !== 1'b0 || cif.comp_req !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_player_pulse_%0d: got wm=%b req=%b, need 0/0", bad[k], wrong_move, cif.comp_req);
      end
    end
  endtask

  task automatic test_player_win();
    new_game();
    n_checks++;
    if (board !== 18'h0) begin
      n_fail++;
      $display("FAIL start_clear: got board=%h, need 0", board);
    end
    do_play(0); tick(); comp_move(3); tick();
    do_play(1); tick(); comp_move(4); tick();
    do_play(2); tick();
    m_board[0] = 1; m_board[1] = 1; m_board[2] = 1; m_board[3] = 2; m_board[4] = 2;
    n_checks++;
    if (win !== 1'b1 || winner !== 2'b01 || busy !== 1'b0 || timeout !== 1'b0 || board !== m_bits()) begin
      n_fail++;
      $display("FAIL player_win: got win=%b winner=%b busy=%b to=%b board=%h, need 1/01/0/0/%h",
               win, winner, busy, timeout, board, m_bits());
    end
    do_play(5);
    tick();
    n_checks++;
    if (board !== m_bits() || win !== 1'b1 || wrong_move !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL over_hold: got board=%h win=%b wm=%b busy=%b, need %h/1/0/0",
               board, win, wrong_move, busy, m_bits());
    end
    new_game();
    n_checks++;
    if (board !== 18'h0 || win !== 1'b0 || winner !== 2'b00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL restart: got board=%h win=%b winner=%b busy=%b, need 0/0/00/0", board, win, winner, busy);
    end
  endtask

  task automatic test_timeout();
    new_game();
    do_play(0);
    tick();
    for (int c = 1; c < TIMEOUT; c++) begin
      n_checks++;
      if (cif.comp_req !== 1'b1 || timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_wait_%0d: got req=%b to=%b, need 1/0", c, cif.comp_req, timeout);
      end
      tick();
    end
    tick();
    n_checks++;
    if (timeout !== 1'b1 || win !== 1'b1 || winner !== 2'b01 || cif.comp_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_fire: got to=%b win=%b winner=%b req=%b busy=%b, need 1/1/01/0/0",
               timeout, win, winner, cif.comp_req, busy);
    end
    new_game();
    do_play(0);
    tick();
    for (int c = 1; c < TIMEOUT; c++) tick();
    comp_move(1);
    m_board[0] = 1; m_board[1] = 2;
    n_checks++;
    if (timeout !== 1'b0 || win !== 1'b0 || board !== m_bits() || cif.comp_req !== 1'b0) begin
      n_fail++;
      $display("FAIL deadline_accept: got to=%b win=%b board=%h req=%b, need 0/0/%h/0",
               timeout, win, board, cif.comp_req, m_bits());
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL deadline_idle: got busy=%b to=%b, need 0/0", busy, timeout);
    end
  endtask

  task automatic test_comp_err_and_draw();
    int seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    new_game();
    do_play(0);
    m_board[0] = 1;
    tick();
    comp_move(0);
    n_checks++;
    if (comp_err !== 1'b1 || wrong_move !== 1'b0 || cif.comp_req !== 1'b1 || board !== m_bits()) begin
      n_fail++;
      $display("FAIL comp_err: got ce=%b wm=%b req=%b board=%h, need 1/0/1/%h",
               comp_err, wrong_move, cif.comp_req, board, m_bits());
    end
    for (int k = 1; k < 9; k++) begin
      if (k % 2 == 1) begin
        comp_move(seq[k]);
        m_board[seq[k]] = 2;
      end else begin
        do_play(seq[k]);
        m_board[seq[k]] = 1;
      end
      tick();
    end
    n_checks++;
    if (filled !== 1'b1 || win !== 1'b0 || winner !== 2'b00 || busy !== 1'b0 ||
        cif.comp_req !== 1'b0 || board !== m_bits()) begin
      n_fail++;
      $display("FAIL draw: got f=%b win=%b winner=%b busy=%b req=%b board=%h, need 1/0/00/0/0/%h",
               filled, win, winner, busy, cif.comp_req, board, m_bits());
    end
  endtask

  task automatic test_midgame_reset();
    new_game();
    do_play(4);
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (cif.comp_req !== 1'b0 || board !== 18'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got req=%b board=%h busy=%b, need 0/0/0", cif.comp_req, board, busy);
    end
    tick();
    reset = 1'b1;
    m_clear();
    tick();
    do_play(0);
    m_board[0] = 1;
    tick();
    n_checks++;
    if (board !== m_bits() || cif.comp_req !== 1'b1) begin
      n_fail++;
      $display("FAIL resume: got board=%h req=%b, need %h/1", board, cif.comp_req, m_bits());
    end
  endtask

  task automatic test_random_games();
    for (int g = 0; g < 8; g++) begin
      bit over;
      int guard;
      new_game();
      over = 1'b0;
      guard = 0;
      while (!over && guard < 40) begin
        int p;
        bit legal;
        guard++;
        p = $urandom_range(0, 10);
        legal = m_legal(p);
        do_play(p);
        if (legal) m_board[p] = 1;
        n_checks++;
        if (wrong_move !== !legal || board !== m_bits() || comp_err !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_play g%0d p%0d: got wm=%b ce=%b board=%h, need %b/0/%h",
                   g, p, wrong_move, comp_err, board, !legal, m_bits());
        end
        if (!legal) continue;
        tick();
        if (m_wins(1) || m_full()) begin
          n_checks++;
          if (win !== m_wins(1) || winner !== (m_wins(1) ? 2'b01 : 2'b00) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_end_player g%0d: got win=%b winner=%b busy=%b, need %b/%b/0",
                     g, win, winner, busy, m_wins(1), m_wins(1) ? 2'b01 : 2'b00);
          end
          over = 1'b1;
        end else begin
          bit accepted;
          accepted = 1'b0;
          for (int a = 0; a < 3 && !accepted; a++) begin
            int q;
            bit ok;
            if (a == 2) begin
              q = $urandom_range(0, 8);
              while (m_board[q] != 0) q = (q + 1) % 9;
            end else begin
              q = $urandom_range(0, 11);
            end
            ok = m_legal(q);
            comp_move(q);
            if (ok) m_board[q] = 2;
            n_checks++;
            if (comp_err !== !ok || cif.comp_req !== !ok || board !== m_bits() ||
                wrong_move !== 1'b0 || timeout !== 1'b0) begin
              n_fail++;
              $display("FAIL rnd_comp g%0d q%0d: got ce=%b req=%b board=%h wm=%b to=%b, need %b/%b/%h/0/0",
                       g, q, comp_err, cif.comp_req, board, wrong_move, timeout, !ok, !ok, m_bits());
            end
            accepted = ok;
          end
          tick();
          n_checks++;
          if (win !== m_wins(2) || winner !== (m_wins(2) ? 2'b10 : 2'b00) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_after_comp g%0d: got win=%b winner=%b busy=%b, need %b/%b/0",
                     g, win, winner, busy, m_wins(2), m_wins(2) ? 2'b10 : 2'b00);
          end
          if (m_wins(2)) over = 1'b1;
        end
      end
      n_checks++;
      if (!over) begin
        n_fail++;
        $display("FAIL rnd_game_bound g%0d: game did not end within %0d moves, need end", g, guard);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_handoff();
    test_illegal_player();
    test_player_win();
    test_timeout();
    test_comp_err_and_draw();
    test_midgame_reset();
    test_random_games();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
